vram_addr_gen: RTL and testbench

//  Responder side of the background fetch interface. Consumes fetch_nt/fetch_attr/fetch_chr and pattern_idx,

---
 rtl/vram_addr_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_vram_addr_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_addr_gen.sv
// PPU background fetch responder: owns the v/t scroll registers, drives the
// 14-bit PPU bus address, and serves CPU CTRL/SCROLL/ADDR/DATA traffic.
module vram_addr_gen #(
   parameter int unsigned ADDR_W    = 14,
   parameter logic [13:0] NT_BASE   = 14'h2000,
   parameter logic [9:0]  AT_OFFSET = 10'h3C0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rend,
   input  logic              fetch_nt,
   input  logic              fetch_attr,
   input  logic              fetch_chr,
   input  logic [12:0]       pattern_idx,
   input  logic              inc_cx,
   input  logic              inc_y,
   input  logic              return00,
   input  logic              reg_wr,
   input  logic              reg_rd,
   input  logic [2:0]        reg_addr,
   input  logic [7:0]        reg_din,
   input  logic [7:0]        vram_din,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_rd,
   output logic              vram_wr,
   output logic [7:0]        vram_dout,
   output logic [7:0]        data_o,
   output logic [1:0]        attr_o,
   output logic [2:0]        fine_x,
   output logic [7:0]        ppudata_o
);

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd2;
   localparam logic [2:0] REG_SCROLL = 3'd5;
   localparam logic [2:0] REG_ADDR   = 3'd6;
   localparam logic [2:0] REG_DATA   = 3'd7;

   logic [14:0] v_q, v_d, t_q, t_d;
   logic [2:0]  fine_x_q, fine_x_d;
   logic        w_q, w_d;
   logic        inc32_q, inc32_d;
   logic [7:0]  rd_buf_q, rd_buf_d;
   logic        rd_pend_q, rd_pend_d;
   logic [1:0]  qsel_q, qsel_d;
   logic        hcopy_q, hcopy_d;

   logic        fetch_any_s;
   logic        data_wr_s, data_rd_s, data_acc_s;
   logic        bus_wr_s, bus_rd_s;
   logic        cpu_inc_s, ren_data_s;
   logic        addr_load_s;
   logic [14:0] v_cx_s, v_y_s, v_hc_s, v_ren_s;

   // Coarse X wraps 31 -> 0 and flips the horizontal nametable bit.
   function automatic logic [14:0] incr_cx(input logic [14:0] v);
      logic [14:0] r;
      r = v;
      if (v[4:0] == 5'd31) begin
         r[4:0] = 5'd0;
         r[10]  = ~v[10];
      end else begin
         r[4:0] = v[4:0] + 5'd1;
      end
      return r;
   endfunction

   // Row 29 is the last tile row; 30/31 are attribute rows that wrap without a nametable flip.
   function automatic logic [14:0] incr_y(input logic [14:0] v);
      logic [14:0] r;
      r = v;
      if (v[14:12] != 3'd7) begin
         r[14:12] = v[14:12] + 3'd1;
      end else begin
         r[14:12] = 3'd0;
         case (v[9:5])
            5'd29: begin
               r[9:5] = 5'd0;
               r[11]  = ~v[11];
            end
            5'd31:   r[9:5] = 5'd0;
            default: r[9:5] = v[9:5] + 5'd1;
         endcase
      end
      return r;
   endfunction

   assign fetch_any_s = fetch_nt | fetch_attr | fetch_chr;
   assign data_wr_s   = reg_wr && (reg_addr == REG_DATA);
   assign data_rd_s   = reg_rd && !reg_wr && (reg_addr == REG_DATA);
   assign data_acc_s  = data_wr_s | data_rd_s;
   assign bus_wr_s    = data_wr_s && !rend && !fetch_any_s;
   assign bus_rd_s    = data_rd_s && !rend && !fetch_any_s;
   assign cpu_inc_s   = data_acc_s && !rend && !fetch_any_s;
   assign ren_data_s  = data_acc_s && rend;

   assign v_cx_s  = (inc_cx || ren_data_s) ? incr_cx(v_q) : v_q;
   assign v_y_s   = (inc_y || ren_data_s) ? incr_y(v_cx_s) : v_cx_s;
   assign v_hc_s  = hcopy_q ? {v_y_s[14:11], t_q[10], v_y_s[9:5], t_q[4:0]} : v_y_s;
   assign v_ren_s = (return00 && rend) ? {t_q[14:11], v_hc_s[10], t_q[9:5], v_hc_s[4:0]} : v_hc_s;

   // CPU register writes into t/fine_x/w, and next value of v.
   always_comb begin
      t_d         = t_q;
      w_d         = w_q;
      fine_x_d    = fine_x_q;
      inc32_d     = inc32_q;
      addr_load_s = 1'b0;
      if (reg_wr) begin
         case (reg_addr)
            REG_CTRL: begin
               t_d[11:10] = reg_din[1:0];
               inc32_d    = reg_din[2];
            end
            REG_SCROLL: begin
               if (!w_q) begin
                  t_d[4:0] = reg_din[7:3];
                  fine_x_d = reg_din[2:0];
                  w_d      = 1'b1;
               end else begin
                  t_d[14:12] = reg_din[2:0];
                  t_d[9:5]   = reg_din[7:3];
                  w_d        = 1'b0;
               end
            end
            REG_ADDR: begin
               if (!w_q) begin
                  t_d[13:8] = reg_din[5:0];
                  t_d[14]   = 1'b0;
                  w_d       = 1'b1;
               end else begin
                  t_d[7:0]    = reg_din;
                  addr_load_s = 1'b1;
                  w_d         = 1'b0;
               end
            end
            default: begin
               t_d = t_q;
            end
         endcase
      end else if (reg_rd && (reg_addr == REG_STATUS)) begin
         w_d = 1'b0;
      end else begin
         w_d = w_q;
      end

      if (addr_load_s) begin
         v_d = t_d;
      end else if (cpu_inc_s) begin
         v_d = v_q + (inc32_q ? 15'd32 : 15'd1);
      end else begin
         v_d = v_ren_s;
      end
   end

   // Side registers: read buffer pipeline, attribute quadrant, pending horizontal copy.
   always_comb begin
      rd_pend_d = bus_rd_s;
      hcopy_d   = inc_y;
      if (rd_pend_q) begin
         rd_buf_d = vram_din;
      end else begin
         rd_buf_d = rd_buf_q;
      end
      if (fetch_attr) begin
         qsel_d = {v_q[6], v_q[1]};
      end else begin
         qsel_d = qsel_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q       <= 15'd0;
         t_q       <= 15'd0;
         fine_x_q  <= 3'd0;
         w_q       <= 1'b0;
         inc32_q   <= 1'b0;
         rd_buf_q  <= 8'd0;
         rd_pend_q <= 1'b0;
         qsel_q    <= 2'd0;
         hcopy_q   <= 1'b0;
      end else begin
         v_q       <= v_d;
         t_q       <= t_d;
         fine_x_q  <= fine_x_d;
         w_q       <= w_d;
         inc32_q   <= inc32_d;
         rd_buf_q  <= rd_buf_d;
         rd_pend_q <= rd_pend_d;
         qsel_q    <= qsel_d;
         hcopy_q   <= hcopy_d;
      end
   end

   // Bus address mux: pattern fetch outranks attribute, attribute outranks nametable.
   always_comb begin
      if (fetch_chr) begin
         vram_addr = {1'b0, pattern_idx};
      end else if (fetch_attr) begin
         vram_addr = NT_BASE | {2'b00, v_q[11:10], AT_OFFSET} | {8'h00, v_q[9:7], v_q[4:2]};
      end else if (fetch_nt) begin
         vram_addr = NT_BASE | {2'b00, v_q[11:0]};
      end else begin
         vram_addr = v_q[13:0];
      end
   end

   // Attribute byte holds four 2-bit quadrants; pick the one latched at the attr fetch.
   always_comb begin
      case (qsel_q)
         2'd0:    attr_o = vram_din[1:0];
         2'd1:    attr_o = vram_din[3:2];
         2'd2:    attr_o = vram_din[5:4];
         default: attr_o = vram_din[7:6];
      endcase
   end

   assign vram_rd   = fetch_any_s | bus_rd_s;
   assign vram_wr   = bus_wr_s;
   assign vram_dout = bus_wr_s ? reg_din : 8'h00;
   assign data_o    = vram_din;
   assign fine_x    = fine_x_q;
   assign ppudata_o = rd_buf_q;

endmodule

// File: tb/tb_vram_addr_gen.sv
// Directed bench for vram_addr_gen: a render-increment vector table plus
// hand sequences for CPU registers, fetches, PPUDATA and async reset.
module tb_vram_addr_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rend, fetch_nt, fetch_attr, fetch_chr;
   logic [12:0] pattern_idx;
   logic        inc_cx, inc_y, return00, reg_wr, reg_rd;
   logic [2:0]  reg_addr;
   logic [7:0]  reg_din;
   logic [7:0]  vram_din = 8'h00;
   logic [13:0] vram_addr;
   logic        vram_rd, vram_wr;
   logic [7:0]  vram_dout, data_o, ppudata_o;
   logic [1:0]  attr_o;
   logic [2:0]  fine_x;

   logic [7:0]  mem [0:16383];
   int          n_pass = 0;
   int          n_tot  = 0;

   typedef struct {
      logic [14:0] v0;
      logic        cx;
      logic        y;
      logic [14:0] ve;
   } vec_t;
   vec_t vecs [8];

   vram_addr_gen dut (
      .clk(clk), .rst_n(rst_n), .rend(rend), .fetch_nt(fetch_nt), .fetch_attr(fetch_attr),
      .fetch_chr(fetch_chr), .pattern_idx(pattern_idx), .inc_cx(inc_cx), .inc_y(inc_y),
      .return00(return00), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .reg_din(reg_din), .vram_din(vram_din), .vram_addr(vram_addr), .vram_rd(vram_rd),
      .vram_wr(vram_wr), .vram_dout(vram_dout), .data_o(data_o), .attr_o(attr_o),
      .fine_x(fine_x), .ppudata_o(ppudata_o)
   );

   always #5 clk = ~clk;

   // Read-only bus memory: data appears the cycle after the address.
   always @(posedge clk) begin
      if (vram_rd) vram_din <= mem[vram_addr];
   end

   initial begin
      #200000;
      $display("FAIL timeout: run did not complete");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      reg_wr = 1'b1; reg_addr = a; reg_din = d;
      tick();
      reg_wr = 1'b0;
   endtask

   task automatic set_v(input logic [14:0] x);
      wr(3'd6, {2'b00, x[13:8]});
      wr(3'd6, x[7:0]);
      wr(3'd5, {x[4:0], 3'b000});
      wr(3'd5, {x[9:5], x[14:12]});
      rend = 1'b1; return00 = 1'b1;
      tick();
      rend = 1'b0; return00 = 1'b0;
   endtask

   initial begin
      vecs[0] = '{15'h001F, 1'b1, 1'b0, 15'h0400};
      vecs[1] = '{15'h0005, 1'b1, 1'b0, 15'h0006};
      vecs[2] = '{15'h041F, 1'b1, 1'b0, 15'h0000};
      vecs[3] = '{15'h73A0, 1'b0, 1'b1, 15'h0800};
      vecs[4] = '{15'h1000, 1'b0, 1'b1, 15'h2000};
      vecs[5] = '{15'h73E0, 1'b0, 1'b1, 15'h0000};
      vecs[6] = '{15'h7340, 1'b0, 1'b1, 15'h0360};
      vecs[7] = '{15'h7BBF, 1'b1, 1'b1, 15'h0400};

      for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
      mem[14'h2000] = 8'h11; mem[14'h2001] = 8'h22; mem[14'h2002] = 8'h33;
      mem[14'h2FC0] = 8'hE4; mem[14'h2BEF] = 8'hE4;

      rst_n = 1'b0; rend = 1'b0; fetch_nt = 1'b0; fetch_attr = 1'b0; fetch_chr = 1'b0;
      pattern_idx = 13'd0; inc_cx = 1'b0; inc_y = 1'b0; return00 = 1'b0;
      reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 3'd0; reg_din = 8'd0;
      #12;
      chk("rst_addr", vram_addr, 14'h0000);
      chk("rst_rd", vram_rd, 1'b0);
      chk("rst_wr", vram_wr, 1'b0);
      chk("rst_finex", fine_x, 3'd0);
      chk("rst_ppudata", ppudata_o, 8'h00);
      rst_n = 1'b1;
      tick();

      // SCROLL pair
      wr(3'd5, 8'h7D);
      chk("scroll_w1", dut.w_q, 1'b1);
      wr(3'd5, 8'h5E);
      chk("scroll_t", dut.t_q, 15'h616F);
      chk("scroll_finex", fine_x, 3'd5);
      chk("scroll_w0", dut.w_q, 1'b0);

      // ADDR pair and PPUDATA write
      wr(3'd6, 8'h23); wr(3'd6, 8'hC5);
      chk("addr_v", dut.v_q, 15'h23C5);
      chk("addr_bus", vram_addr, 14'h23C5);
      reg_wr = 1'b1; reg_addr = 3'd7; reg_din = 8'hAA;
      #2;
      chk("pdw_wr", vram_wr, 1'b1);
      chk("pdw_addr", vram_addr, 14'h23C5);
      chk("pdw_dout", vram_dout, 8'hAA);
      chk("pdw_rd", vram_rd, 1'b0);
      tick();
      reg_wr = 1'b0;
      chk("pdw_inc1", dut.v_q, 15'h23C6);
      wr(3'd0, 8'h04); wr(3'd6, 8'h23); wr(3'd6, 8'hC5); wr(3'd7, 8'h5A);
      chk("pdw_inc32", dut.v_q, 15'h23E5);
      wr(3'd0, 8'h00);

      // render increment table
      for (int i = 0; i < 8; i++) begin
         set_v(vecs[i].v0);
         chk($sformatf("setv%0d", i), dut.v_q, vecs[i].v0);
         inc_cx = vecs[i].cx; inc_y = vecs[i].y;
         tick();
         inc_cx = 1'b0; inc_y = 1'b0;
         chk($sformatf("incv%0d", i), dut.v_q, vecs[i].ve);
         tick();
      end

      // coarse Y 31 wrap, then horizontal copy beating a same-cycle inc_cx
      set_v(15'h73E5);
      wr(3'd5, 8'h48); reg_rd = 1'b1; reg_addr = 3'd2; tick(); reg_rd = 1'b0;
      wr(3'd0, 8'h01);
      inc_y = 1'b1; tick(); inc_y = 1'b0;
      chk("y31_wrap", dut.v_q, 15'h0005);
      inc_cx = 1'b1; tick(); inc_cx = 1'b0;
      chk("hcopy", dut.v_q, 15'h0409);

      // vertical copy only while rendering
      return00 = 1'b1; tick(); return00 = 1'b0;
      chk("ret00_norend", dut.v_q, 15'h0409);
      return00 = 1'b1; rend = 1'b1; tick(); return00 = 1'b0; rend = 1'b0;
      chk("ret00_copy", dut.v_q, 15'h77E9);

      // attribute / nametable / pattern fetches
      set_v(15'h0C63);
      fetch_attr = 1'b1; rend = 1'b1; #2;
      chk("attr_addr_a", vram_addr, 14'h2FC0);
      chk("attr_rd", vram_rd, 1'b1);
      tick(); fetch_attr = 1'b0; rend = 1'b0; #2;
      chk("attr_data", data_o, 8'hE4);
      chk("attr_q3", attr_o, 2'd3);
      tick();
      set_v(15'h0A9D);
      fetch_attr = 1'b1; rend = 1'b1; #2;
      chk("attr_addr_b", vram_addr, 14'h2BEF);
      tick(); fetch_attr = 1'b0; #2;
      chk("attr_q0", attr_o, 2'd0);
      fetch_nt = 1'b1; #2;
      chk("nt_addr", vram_addr, 14'h2A9D);
      tick(); fetch_nt = 1'b0;
      fetch_chr = 1'b1; fetch_attr = 1'b1; pattern_idx = 13'h1ABC; #2;
      chk("chr_prio", vram_addr, 14'h1ABC);
      tick(); fetch_chr = 1'b0; fetch_attr = 1'b0; rend = 1'b0;
      fetch_nt = 1'b1; reg_wr = 1'b1; reg_addr = 3'd7; reg_din = 8'h77; #2;
      chk("fetch_blocks_cpu", vram_wr, 1'b0);
      tick(); fetch_nt = 1'b0; reg_wr = 1'b0;

      // buffered PPUDATA reads
      wr(3'd6, 8'h20); wr(3'd6, 8'h00);
      reg_rd = 1'b1; reg_addr = 3'd7; #2;
      chk("pdr0_val", ppudata_o, 8'h00);
      chk("pdr0_rd", vram_rd, 1'b1);
      chk("pdr0_addr", vram_addr, 14'h2000);
      tick(); reg_rd = 1'b0; tick();
      reg_rd = 1'b1; #2;
      chk("pdr1_val", ppudata_o, 8'h11);
      chk("pdr1_addr", vram_addr, 14'h2001);
      tick(); reg_rd = 1'b0; tick();
      chk("pdr_buf", ppudata_o, 8'h22);
      chk("pdr_v", dut.v_q, 15'h2002);

      // PPUDATA while rendering: no bus, coarse X and Y step
      rend = 1'b1; reg_wr = 1'b1; reg_addr = 3'd7; reg_din = 8'h55; #2;
      chk("pdrend_wr", vram_wr, 1'b0);
      tick(); reg_wr = 1'b0; rend = 1'b0;
      chk("pdrend_v", dut.v_q, 15'h3003);

      // second ADDR write overrides same-cycle render update
      wr(3'd6, 8'h01);
      reg_wr = 1'b1; reg_addr = 3'd6; reg_din = 8'h1F; inc_cx = 1'b1; rend = 1'b1;
      tick();
      reg_wr = 1'b0; inc_cx = 1'b0; rend = 1'b0;
      chk("addr_override", dut.v_q, 15'h011F);

      // async reset with a read and a copy in flight
      wr(3'd6, 8'h20); wr(3'd6, 8'h00);
      reg_rd = 1'b1; reg_addr = 3'd7; inc_y = 1'b1;
      tick();
      reg_rd = 1'b0; inc_y = 1'b0;
      rst_n = 1'b0; #1;
      chk("arst_v", dut.v_q, 15'h0000);
      chk("arst_addr", vram_addr, 14'h0000);
      #1 rst_n = 1'b1;
      tick(); tick();
      chk("arst_buf", ppudata_o, 8'h00);
      chk("arst_v_hold", dut.v_q, 15'h0000);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
